// File: rtl/pio_bank_pkg.sv
// pio_bank shared definitions: register map,
// ID magic and debounce counter sizing.
package pio_bank_pkg;

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd2;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd3;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd4;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd5;
  localparam logic [2:0] ADDR_EDGE_POL = 3'd6;
  localparam logic [2:0] ADDR_ID       = 3'd7;

  localparam logic [7:0] ID_MAGIC = 8'h50;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pio_bank_if.sv
// Avalon-MM slave bundle for pio_bank:
// word address, strobes, data, readdata.
interface pio_bank_if;

  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );

endinterface

// File: rtl/pio_bank_debounce.sv
// One input channel: synchroniser chain feeding
// a stable-count debouncer.
module pio_debounce
  import pio_bank_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   sync_q;

  assign sync_q = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      if (sync_q == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout <= sync_q;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pio_bank.sv
// Configurable PIO bank: debounced inputs, edge
// capture, maskable irq, set/clear output register.
module pio_bank
  import pio_bank_pkg::*;
#(
  parameter int IN_WIDTH        = 8,
  parameter int OUT_WIDTH       = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  pio_bank_if.slave            avs,
  input  logic [IN_WIDTH-1:0]  in_export,
  output logic [OUT_WIDTH-1:0] out_export,
  output logic                 irq
);

  localparam logic [31:0] ID_VALUE = {
    ID_MAGIC, 8'h00, 8'(IN_WIDTH), 8'(OUT_WIDTH)
  };

  logic [IN_WIDTH-1:0]  din;
  logic [IN_WIDTH-1:0]  din_q;
  logic [IN_WIDTH-1:0]  edge_cap;
  logic [IN_WIDTH-1:0]  irq_mask;
  logic [IN_WIDTH-1:0]  edge_pol;
  logic [IN_WIDTH-1:0]  hit;
  logic [IN_WIDTH-1:0]  wd_in;
  logic [OUT_WIDTH-1:0] wd_out;
  logic [OUT_WIDTH-1:0] data_out;
  logic [31:0]          rdata;
  logic [2:0]           addr;
  logic                 wr;
  logic                 rd;
  logic                 unused_wd;

  assign addr   = avs.avs_address;
  assign wr     = avs.avs_write;
  assign rd     = avs.avs_read & ~avs.avs_write;
  assign wd_in  = avs.avs_writedata[IN_WIDTH-1:0];
  assign wd_out = avs.avs_writedata[OUT_WIDTH-1:0];
  assign unused_wd = ^avs.avs_writedata;

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_in
    pio_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk (clk_clk),
      .rst (reset_reset),
      .din (in_export[i]),
      .dout(din[i])
    );
  end

  // Edge seen on the debounced level; polarity
  // only qualifies new transitions.
  assign hit = (din & ~din_q & edge_pol)
             | (~din & din_q & ~edge_pol);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      din_q    <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
      edge_pol <= '1;
      data_out <= OUT_RESET;
      avs.avs_readdata <= '0;
    end else begin
      din_q <= din;
      if (wr && addr == ADDR_EDGE_CAP)
        edge_cap <= (edge_cap & ~wd_in) | hit;
      else
        edge_cap <= edge_cap | hit;
      if (wr) begin
        unique case (1'b1)
          (addr == ADDR_DATA_OUT): data_out <= wd_out;
          (addr == ADDR_OUT_SET):
            data_out <= data_out | wd_out;
          (addr == ADDR_OUT_CLR):
            data_out <= data_out & ~wd_out;
          (addr == ADDR_IRQ_MASK): irq_mask <= wd_in;
          (addr == ADDR_EDGE_POL): edge_pol <= wd_in;
          default: ;
        endcase
      end
      if (rd) avs.avs_readdata <= rdata;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (addr == ADDR_DATA_IN):  rdata = 32'(din);
      (addr == ADDR_DATA_OUT): rdata = 32'(data_out);
      (addr == ADDR_EDGE_CAP): rdata = 32'(edge_cap);
      (addr == ADDR_IRQ_MASK): rdata = 32'(irq_mask);
      (addr == ADDR_EDGE_POL): rdata = 32'(edge_pol);
      (addr == ADDR_ID):       rdata = ID_VALUE;
      default:                 rdata = '0;
    endcase
  end

  assign out_export = data_out;
  assign irq        = |(edge_cap & irq_mask);

endmodule

// File: doc/pio_bank.md
# pio_bank

Parametrised Avalon-MM parallel-I/O bank that replaces the fixed per-peripheral LED, switch and button PIOs in the SoC with one configurable slave. It provides:
- Synchronised, debounced inputs.
- Per-bit edge capture with a programmable polarity.
- A maskable level interrupt.
- An output register with atomic set/clear aliases.

It sits on the Platform Designer interconnect next to the SDRAM controller. It exports `in_export` to board switches/buttons and `out_export` to LEDs.

## Interface

Parameters:
- IN_WIDTH, 8: number of input channels, 1..32.
- OUT_WIDTH, 8: number of output channels, 1..32.
- SYNC_STAGES, 2: synchroniser flops per input, at least 2.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a new input level (10 ms at 50 MHz), at least 1.
- OUT_RESET, 0: reset value of the output register.

Ports:
- clk_clk  input  1  sole clock for the block.
- reset_reset  input  1  synchronous, active-high reset.
- avs_address  input  3  word address of the register.
- avs_read  input  1  read strobe.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data.
- avs_readdata  output  32  read data; fixed read latency of 1.
- in_export  input  IN_WIDTH  asynchronous board inputs.
- out_export  output  OUT_WIDTH  output register contents.
- irq  output  1  level interrupt.

## Operation

Register map (word addresses):
- 0 DATA_IN (RO): debounced input levels.
- 1 DATA_OUT (RW): output register.
- 2 OUT_SET (WO): writing 1 to a bit sets that output bit. Reads return 0.
- 3 OUT_CLR (WO): writing 1 to a bit clears that output bit. Reads return 0.
- 4 EDGE_CAP (R/W1C): sticky per-bit edge flags; write 1 to clear.
- 5 IRQ_MASK (RW): per-bit interrupt enable.
- 6 EDGE_POL (RW): per-bit polarity; 1 = capture rising edges, 0 = capture falling edges.
- 7 ID (RO): {8'h50, 8'h00, IN_WIDTH[7:0], OUT_WIDTH[7:0]}.

General rules:
- Register bits above IN_WIDTH/OUT_WIDTH read 0 and ignore writes.
- Writes to read-only addresses have no effect.
- An asserted avs_read together with avs_write is treated as a write only.

Input path, per bit:
- A SYNC_STAGES-deep synchroniser feeds a debouncer.
- The debouncer counter resets whenever the synchronised value equals the debounced value.
- Otherwise it increments. When the count reaches DEBOUNCE_CYCLES-1 on a differing sample, the debounced value flips and the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES never changes DATA_IN.

Edge capture:
- A qualifying transition of the debounced value (rising or falling, per EDGE_POL) sets the EDGE_CAP bit.
- If a set and a W1C hit the same bit in the same cycle, the set wins.
- Changing EDGE_POL does not alter EDGE_CAP.

Interrupt:
- irq = |(EDGE_CAP & IRQ_MASK), computed from registers with no extra flop.

Reset values:
- DATA_IN, EDGE_CAP, IRQ_MASK and all debounce counters: 0.
- EDGE_POL: all ones.
- DATA_OUT: OUT_RESET.
- avs_readdata: 0.
- irq: 0.
- Synchroniser flops: 0.
- Reset asserted mid-debounce discards the partial count. A post-reset input already at 1 produces a rising edge after the normal debounce time.

## Timing

- Writes take effect at the clock edge where avs_write is sampled. out_export shows the new value on the following cycle.
- Reads: avs_readdata is valid the cycle after avs_read and holds its value until the next read.
- Input latency, from a stable pin change in cycle 0:
  - Synchronised value changes at cycle SYNC_STAGES.
  - DATA_IN changes at cycle SYNC_STAGES+DEBOUNCE_CYCLES.
  - EDGE_CAP bit and irq assert one cycle after that.
- irq deasserts the cycle after the W1C write that clears the last unmasked flag, or after the mask write that covers it.
- Throughput: one access per cycle; no wait states.

## Structure

- Package pio_bank_pkg holds the register offset localparams (ADDR_DATA_IN … ADDR_ID), the ID magic byte, and a function for the debounce counter width, $clog2(DEBOUNCE_CYCLES+1).
- Sub-module pio_debounce handles one bit (synchroniser, counter, debounced output). It is instantiated IN_WIDTH times with a generate loop.
- The top level contains the register file, edge logic, read mux and irq.

## Test plan

Run with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, IN_WIDTH=8, OUT_WIDTH=8, OUT_RESET=8'hA5.

- Reset, then read all eight addresses -> DATA_OUT=0xA5, EDGE_POL=0xFF, ID=0x50000808, all others 0; irq=0.
- Write DATA_OUT=0x0F, then OUT_SET=0x30, then OUT_CLR=0x01 -> out_export reads 0x0F, then 0x3F, then 0x3E, one cycle after each write.
- Drive in_export[2] 0->1 with a 3-cycle glitch, then a stable level -> DATA_IN bit 2 stays 0 during the glitch and goes to 1 exactly 6 cycles after the stable change; EDGE_CAP=0x04 the cycle after.
- IRQ_MASK=0x04, trigger a bit-2 rising edge -> irq=1. Write EDGE_CAP=0x04 -> irq=0 the next cycle.
- Same cycle as a new bit-2 edge, write W1C 0x04 -> EDGE_CAP bit 2 remains 1.
- EDGE_POL=0x00, bit 5 goes 1->0 -> EDGE_CAP bit 5 sets. Bit 5 then goes 0->1 -> no new capture. Assert reset mid-debounce -> DATA_IN=0 and no capture.
